aes_inv_cipher_iter: RTL and testbench
======================================

Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryption core: one inverse round per clock, with on-the-fly inverse key schedule. It is the decrypt-direction counterpart of the encryption datapath.
- Accepts ciphertext plus the original cipher key over a valid/ready handshake. First expands forward to round key 10, then walks the key schedule backwards while applying the inverse rounds.
- Sits between the block-mode controller and the output buffer. Reuses inv_shift_row combinationally.

Parameters:
- KEY_CACHE, 1, when 1 retains the last key and its rk10 so that a repeated key skips forward expansion.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ciphertext/key presented
- in_ready  output  1  core can accept a block
- ciphertext  input  [0:127]  byte 0 = bits [0:7], column-major state (bytes 0-3 = column 0)
- key  input  [0:127]  original AES-128 cipher key, same byte order
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts plaintext
- plaintext  output  [0:127]  decrypted block, same byte order
- busy  output  1  high in KEYEXP or ROUND

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, plaintext=0, busy=0, FSM=IDLE, key cache invalid, round counter=0.
- FSM states: IDLE, KEYEXP, ROUND, DONE. in_ready=1 only in IDLE. in_valid in other states is ignored and holds no side effect.
- Accept (IDLE, in_valid=1) at edge E0:
  - Latch ciphertext into state, latch key into rk.
  - If KEY_CACHE=1, the cache is valid and key equals the cached key: rk<=cached rk10, state<=ciphertext^cached rk10, go to ROUND with r=9.
  - Otherwise go to KEYEXP with i=1.
- KEYEXP, one forward expansion per edge:
  - rk<=expand(rk, rcon[i]).
  - At i=10: state<=state^rk10 (the new key), cache<=key/rk10 and marked valid, go to ROUND with r=9. Otherwise i<=i+1.
- ROUND, per edge:
  - Compute prev = inverse key step of rk using rcon[r+1]: w3=w3'^w2', w2=w2'^w1', w1=w1'^w0', w0=w0'^SubWord(RotWord(w3))^rcon[r+1].
  - r>=1: state<=InvMixColumns(InvSubBytes(inv_shift_row(state))^prev).
  - r=0: state<=InvSubBytes(inv_shift_row(state))^prev, and prev equals the cipher key.
  - rk<=prev. At r=0 go to DONE with plaintext<=result and out_valid<=1. Otherwise r<=r-1.
- Latency:
  - Cache miss: out_valid rises after edge E0+20.
  - Cache hit: out_valid rises after edge E0+10.
- DONE:
  - Hold plaintext and out_valid stable while out_ready=0.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE. in_ready rises the following cycle, so there is no same-cycle overlap.
- Reset mid-operation: abort immediately, no output produced, cache invalidated.
- GF arithmetic: InvMixColumns uses xtime-based multiplication by 0e/0b/0d/09 mod x^8+x^4+x^3+x+1.
- rcon width is 8 bits, placed in the MSB byte of the word.

Decomposition:
- Shared package aes_pkg holds:
  - forward and inverse S-box tables, rcon[1..10];
  - state/word typedefs (128-bit state, 32-bit word);
  - FSM enum;
  - functions xtime, gmul, sub_word, rot_word, inv_mix_column.
- One natural combinational sub-module, aes_inv_round: inputs state, round key, last_round flag; output next state. It instantiates inv_shift_row.
- Key-step logic stays in the top module.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid after edge E0+20. Internal rk after KEYEXP = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734. Cache miss, latency 20.
- Back-to-back same key (C.1 key, ct 69c4...c55a twice) -> second block latency 10, identical plaintext. With KEY_CACHE=0 both blocks take latency 20.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> plaintext and out_valid stable, in_ready=0. Release -> one transfer, in_ready=1 next cycle.
- Reset asserted at E0+7 during KEYEXP -> out_valid stays 0, in_ready=1 after reset. The next C.1 block takes full latency 20 (cache invalidated).
- in_valid pulsed with a different ct while busy -> ignored; the original block's plaintext is unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, tables and GF(2^8) helpers for the inverse cipher core.
package aes_pkg;

  typedef logic [0:127] state_t;   // byte 0 = bits [0:7], column-major
  typedef logic [0:31]  word_t;    // one state column / key word
  typedef logic [1:0]   fsm_t;

  localparam fsm_t ST_IDLE   = 2'd0;
  localparam fsm_t ST_KEYEXP = 2'd1;
  localparam fsm_t ST_ROUND  = 2'd2;
  localparam fsm_t ST_DONE   = 2'd3;

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:2047] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Round constants rcon[1..10]; padded to 16 entries so a 4-bit index is always legal.
  localparam logic [7:0] RCON [0:15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                         8'h40, 8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00,
                                         8'h00, 8'h00};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[8:31], w[0:7]};
  endfunction

  function automatic word_t inv_mix_column(input word_t w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[0:7];
    a1 = w[8:15];
    a2 = w[16:23];
    a3 = w[24:31];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round; the last round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t round_key_i,
  input  logic   last_round_i,
  output state_t state_o
);

  state_t shifted;
  state_t subbed;
  state_t keyed;
  state_t mixed;

  inv_shift_row u_inv_shift_row (
    .state_i(state_i),
    .state_o(shifted)
  );

  for (genvar gi = 0; gi < 16; gi++) begin : g_sub
    assign subbed[8*gi +: 8] = inv_sbox(shifted[8*gi +: 8]);
  end

  assign keyed = subbed ^ round_key_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mixed[32*gi +: 32] = inv_mix_column(keyed[32*gi +: 32]);
  end

  assign state_o = last_round_i ? keyed : mixed;

endmodule

// File: rtl/inv_shift_row.sv
// InvShiftRows: row r of the column-major state rotates right by r columns.
module inv_shift_row
  import aes_pkg::*;
(
  input  state_t state_i,
  output state_t state_o
);

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ((COL + 4 - ROW) % 4) * 4 + ROW;
    assign state_o[8*gi +: 8] = state_i[8*SRC +: 8];
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then ten inverse
// rounds walking the key schedule backwards, with an optional last-key cache.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] ciphertext,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] plaintext,
  output logic         busy
);

  fsm_t   fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  state_t rk_q, rk_d;
  state_t pt_q, pt_d;
  logic   out_valid_q, out_valid_d;
  state_t cache_key_q, cache_key_d;
  state_t cache_rk10_q, cache_rk10_d;
  logic   cache_valid_q, cache_valid_d;

  word_t  w0, w1, w2, w3;
  word_t  ew0, ew1, ew2, ew3;
  word_t  pw0, pw1, pw2, pw3;
  state_t exp_rk, prev_rk, round_out;
  logic   cache_hit;

  // Forward step uses rcon[i]; the inverse step recovers rk_r from rk_{r+1} with rcon[r+1].
  assign {w0, w1, w2, w3} = rk_q;
  assign ew0 = w0 ^ sub_word(rot_word(w3)) ^ {RCON[cnt_q], 24'h000000};
  assign ew1 = w1 ^ ew0;
  assign ew2 = w2 ^ ew1;
  assign ew3 = w3 ^ ew2;
  assign exp_rk = {ew0, ew1, ew2, ew3};
  assign pw3 = w3 ^ w2;
  assign pw2 = w2 ^ w1;
  assign pw1 = w1 ^ w0;
  assign pw0 = w0 ^ sub_word(rot_word(pw3)) ^ {RCON[cnt_q + 4'd1], 24'h000000};
  assign prev_rk = {pw0, pw1, pw2, pw3};

  aes_inv_round u_inv_round (
    .state_i     (state_q),
    .round_key_i (prev_rk),
    .last_round_i(cnt_q == 4'd0),
    .state_o     (round_out)
  );

  assign cache_hit = (KEY_CACHE != 0) && cache_valid_q && (key == cache_key_q);
  assign in_ready  = (fsm_q == ST_IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;
  assign busy      = (fsm_q == ST_KEYEXP) || (fsm_q == ST_ROUND);

  // Next-state and datapath selection for the four-state controller.
  always_comb begin
    fsm_d         = fsm_q;
    cnt_d         = cnt_q;
    state_d       = state_q;
    rk_d          = rk_q;
    pt_d          = pt_q;
    out_valid_d   = out_valid_q;
    cache_key_d   = cache_key_q;
    cache_rk10_d  = cache_rk10_q;
    cache_valid_d = cache_valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (cache_hit) begin
            rk_d    = cache_rk10_q;
            state_d = ciphertext ^ cache_rk10_q;
            cnt_d   = 4'd9;
            fsm_d   = ST_ROUND;
          end else begin
            // Key is recorded now; the entry only becomes valid once rk10 exists.
            rk_d          = key;
            state_d       = ciphertext;
            cnt_d         = 4'd1;
            cache_key_d   = key;
            cache_valid_d = 1'b0;
            fsm_d         = ST_KEYEXP;
          end
        end
      end
      ST_KEYEXP: begin
        rk_d = exp_rk;
        if (cnt_q == 4'd10) begin
          state_d       = state_q ^ exp_rk;
          cache_rk10_d  = exp_rk;
          cache_valid_d = 1'b1;
          cnt_d         = 4'd9;
          fsm_d         = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ROUND: begin
        rk_d    = prev_rk;
        state_d = round_out;
        if (cnt_q == 4'd0) begin
          pt_d        = round_out;
          out_valid_d = 1'b1;
          fsm_d       = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = ST_IDLE;
        end
      end
    endcase
  end

  // State registers; reset aborts any block in flight and drops the cached key.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q         <= ST_IDLE;
      cnt_q         <= 4'd0;
      state_q       <= '0;
      rk_q          <= '0;
      pt_q          <= '0;
      out_valid_q   <= 1'b0;
      cache_key_q   <= '0;
      cache_rk10_q  <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      rk_q          <= rk_d;
      pt_q          <= pt_d;
      out_valid_q   <= out_valid_d;
      cache_key_q   <= cache_key_d;
      cache_rk10_q  <= cache_rk10_d;
      cache_valid_q <= cache_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors, key cache, backpressure, abort.
module tb_aes_inv_cipher_iter;

  localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0, out_ready = 1'b0;
  logic [0:127] ct = '0, key = '0;
  logic ir0, ir1, ov0, ov1, busy0, busy1;
  logic [0:127] pt0, pt1;
  bit sel = 1'b0;
  logic ir_s, ov_s, busy_s;
  logic [0:127] pt_s;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [0:127] ct; logic [0:127] key; logic [0:127] pt; int lat; } vec_t;
  typedef struct { logic [0:127] pt; int lat; } exp_t;
  exp_t sb_q[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  aes_inv_cipher_iter #(.KEY_CACHE(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(ir0),
    .ciphertext(ct), .key(key), .out_valid(ov0), .out_ready(out_ready),
    .plaintext(pt0), .busy(busy0));

  aes_inv_cipher_iter #(.KEY_CACHE(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(ir1),
    .ciphertext(ct), .key(key), .out_valid(ov1), .out_ready(out_ready),
    .plaintext(pt1), .busy(busy1));

  always_comb begin
    ir_s   = sel ? ir1 : ir0;
    ov_s   = sel ? ov1 : ov0;
    busy_s = sel ? busy1 : busy0;
    pt_s   = sel ? pt1 : pt0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) in_valid1 = v;
    else in_valid0 = v;
  endtask

  // Present a block at a negedge; the following posedge is E0.
  task automatic start_block(input logic [0:127] c, input logic [0:127] k,
                             input logic [0:127] p, input int lat, input bit push);
    exp_t e;
    int n;
    n = 0;
    while (!ir_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 128'(ir_s), 128'(1));
    ct  = c;
    key = k;
    set_valid(1'b1);
    if (push) begin
      e.pt  = p;
      e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
  endtask

  // Count edges after E0 until out_valid, compare against the scoreboard, then drain.
  task automatic finish_block(input int hold, input bit check_rk, input bit noise);
    exp_t e;
    int lat;
    lat = 0;
    while (!ov_s && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (check_rk && lat == 10) check("rk_after_keyexp", dut0.rk_q, RK10_C1);
      if (noise && lat == 3) begin
        ct = ~ct;
        set_valid(1'b1);
      end
      if (noise && lat == 5) set_valid(1'b0);
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 128'(0), 128'(1));
      return;
    end
    e = sb_q.pop_front();
    $display("block: plaintext=%h latency=%0d (expected %h / %0d)", pt_s, lat, e.pt, e.lat);
    check("plaintext", pt_s, e.pt);
    check("latency", 128'(lat), 128'(e.lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_plaintext", pt_s, e.pt);
      check("hold_out_valid", 128'(ov_s), 128'(1));
      check("hold_in_ready", 128'(ir_s), 128'(0));
    end
    check("done_in_ready_low", 128'(ir_s), 128'(0));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_xfer", 128'(ov_s), 128'(0));
    check("in_ready_after_xfer", 128'(ir_s), 128'(1));
  endtask

  // Start a block and assert reset so that it is sampled at edge E0+rst_edge.
  task automatic abort_block(input logic [0:127] c, input logic [0:127] k, input int rst_edge);
    int seen;
    start_block(c, k, '0, 0, 1'b0);
    for (int i = 1; i < rst_edge; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("busy_before_abort", 128'(busy_s), 128'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 128'(ir_s), 128'(0));
    check("out_valid_in_reset", 128'(ov_s), 128'(0));
    reset = 1'b0;
    #1;
    check("in_ready_after_abort", 128'(ir_s), 128'(1));
    check("busy_after_abort", 128'(busy_s), 128'(0));
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ov_s) seen++;
    end
    $display("abort at E0+%0d: out_valid cycles afterwards=%0d", rst_edge, seen);
    check("no_output_after_abort", 128'(seen), 128'(0));
  endtask

  initial begin
    vecs[0] = '{ct: CT_C1, key: KEY_C1, pt: PT_C1, lat: 20};
    vecs[1] = '{ct: CT_B,  key: KEY_B,  pt: PT_B,  lat: 20};
    vecs[2] = '{ct: CT_C1, key: KEY_C1, pt: PT_C1, lat: 20};
    vecs[3] = '{ct: CT_C1, key: KEY_C1, pt: PT_C1, lat: 10};

    repeat (2) @(negedge clk);
    check("reset_in_ready0", 128'(ir0), 128'(0));
    check("reset_in_ready1", 128'(ir1), 128'(0));
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 128'(ir0), 128'(1));
    check("post_reset_out_valid", 128'(ov0), 128'(0));
    check("post_reset_plaintext", pt0, 128'(0));
    check("post_reset_busy", 128'(busy0), 128'(0));
    @(negedge clk);

    // Table: miss, miss, key change back (miss), repeat key (hit).
    for (int v = 0; v < 4; v++) begin
      start_block(vecs[v].ct, vecs[v].key, vecs[v].pt, vecs[v].lat, 1'b1);
      check("busy_after_accept", 128'(busy_s), 128'(1));
      finish_block(0, v == 0, 1'b0);
    end

    // Backpressure for five cycles on a cache hit.
    start_block(CT_C1, KEY_C1, PT_C1, 10, 1'b1);
    finish_block(5, 1'b0, 1'b0);

    // Stray in_valid with a different ciphertext while busy.
    start_block(CT_C1, KEY_C1, PT_C1, 10, 1'b1);
    finish_block(0, 1'b0, 1'b1);

    // Reset during key expansion, then full latency.
    abort_block(CT_B, KEY_B, 7);
    start_block(CT_C1, KEY_C1, PT_C1, 20, 1'b1);
    finish_block(0, 1'b0, 1'b0);

    // Reset during the rounds of a cache hit must drop the cached key.
    abort_block(CT_C1, KEY_C1, 5);
    start_block(CT_C1, KEY_C1, PT_C1, 20, 1'b1);
    finish_block(0, 1'b0, 1'b0);

    // Without the cache every block takes the full latency.
    sel = 1'b1;
    #1;
    for (int v = 0; v < 2; v++) begin
      start_block(CT_C1, KEY_C1, PT_C1, 20, 1'b1);
      finish_block(0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
